// File: rtl/riscv_fetch_pkg.sv
// riscv_fetch_pkg: shared widths, constants and entry type for the instruction fetch path
package riscv_fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small FIFO of fetched {instr, pc} entries with synchronous flush
module fetch_fifo import riscv_fetch_pkg::*; #(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t din,
  input  logic         pop,
  output fetch_entry_t dout,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);
  fetch_entry_t mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign dout = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end
  always_ff @(posedge clk)
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner issuing 1-cycle imem reads, buffering words and streaming them
// to the core on valid/ready; a redirect flushes buffered and in-flight fetches.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = riscv_fetch_pkg::DEFAULT_RESET_PC,
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = riscv_fetch_pkg::NOP_INSTR
) (
  input  logic        i_clk,
  input  logic        rst,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc
);
  import riscv_fetch_pkg::*;
  localparam int AW = $clog2(DEPTH);
  logic [31:0] pc, issued_pc;
  logic inflight, pop, push, kill, full, empty;
  logic [AW:0] count;
  logic [AW+1:0] credit;
  fetch_entry_t head;
  assign pop = o_valid & i_ready;
  // a redirect in the response cycle discards the returning word
  assign kill = i_redirect;
  assign push = inflight & !kill & !full;
  assign credit = {1'b0, count} + (AW+2)'(inflight) - (AW+2)'(pop);
  assign o_imem_req = rst & !i_redirect & (credit < (AW+2)'(DEPTH));
  assign o_imem_addr = pc;
  assign o_valid = !empty;
  assign o_instr = o_valid ? head.instr : NOP_INSTR;
  assign o_pc = o_valid ? head.pc : '0;
  always_ff @(posedge i_clk) begin
    if (!rst) begin
      pc <= RESET_PC;
      inflight <= 1'b0;
    end else begin
      inflight <= o_imem_req;
      if (i_redirect) pc <= i_redirect_pc & ~32'h3;
      else if (o_imem_req) pc <= pc + 32'd4;
    end
  end
  always_ff @(posedge i_clk)
    if (o_imem_req) issued_pc <= pc;
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (i_clk),
    .rst   (rst),
    .flush (i_redirect),
    .push  (push),
    .din   ('{instr: i_imem_rdata, pc: issued_pc}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );
endmodule
